// File: rtl/hdmi_tx_seq_ctrl.sv
// Power-up / run-time sequencer for the HDMI TX path: PLL reset and lock qualification,
// display reset / data-enable gating, test-pattern mode scheduling and status LED.
module hdmi_tx_seq_ctrl #(
    parameter int PLL_RST_CYCLES     = 128,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRY          = 3,
    parameter int DWELL_CYCLES       = 33554432,
    parameter int MODE_MIN           = 1,
    parameter int MODE_MAX           = 11,
    parameter int LED_DIV_BITS       = 24
) (
    input  logic       SYS_CLK_I,
    input  logic       RST_I,
    input  logic       DISPLAY_ON_I,
    input  logic       LOCKED_I,
    input  logic       AUTO_CYCLE_I,
    input  logic       MODE_NEXT_I,
    output logic       PLL_RST_O,
    output logic       DISP_RST_O,
    output logic       DEN_O,
    output logic [3:0] TPG_MODE_O,
    output logic       MODE_STROBE_O,
    output logic [2:0] STATE_O,
    output logic       FAULT_O,
    output logic       LED_O
);

    localparam int RST_W   = $clog2(PLL_RST_CYCLES + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0]   RTY_LAST   = RTY_W'(MAX_RETRY - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]         MODE_LO    = 4'(MODE_MIN);
    localparam logic [3:0]         MODE_HI    = 4'(MODE_MAX);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t state, next_state;

    logic                    lock_m, lock_s;
    logic [RST_W-1:0]        rst_cnt;
    logic [STB_W-1:0]        stable_cnt;
    logic [TO_W-1:0]         timeout_cnt;
    logic [RTY_W-1:0]        retry_cnt;
    logic [DWELL_W-1:0]      dwell_cnt;
    logic [LED_DIV_BITS-1:0] led_cnt;
    logic [3:0]              mode_adv;
    logic                    stay_wait, stay_active, dwell_done, advance;

    assign STATE_O = state;

    always_ff @(posedge SYS_CLK_I) begin
        if (RST_I) begin
            state <= ST_OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!DISPLAY_ON_I) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:       next_state = ST_PLL_RST;
                ST_PLL_RST:   if (rst_cnt == RST_LAST) next_state = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    // A stable lock completing on the timeout cycle still counts as locked.
                    if (lock_s && stable_cnt == STB_LAST) begin
                        next_state = ST_ACTIVE;
                    end else if (timeout_cnt == TO_LAST) begin
                        next_state = (retry_cnt == RTY_LAST) ? ST_FAULT : ST_PLL_RST;
                    end
                end
                ST_ACTIVE:    if (!lock_s) next_state = ST_WAIT_LOCK;
                ST_FAULT:     next_state = ST_FAULT;
                default:      next_state = ST_OFF;
            endcase
        end
    end

    always_comb begin
        stay_wait   = (state == ST_WAIT_LOCK) && (next_state == ST_WAIT_LOCK);
        stay_active = (state == ST_ACTIVE) && (next_state == ST_ACTIVE);
        dwell_done  = AUTO_CYCLE_I && (dwell_cnt == DWELL_LAST);
        // Manual step and dwell expiry on the same cycle merge into a single advance.
        advance     = stay_active && (MODE_NEXT_I || dwell_done);
        mode_adv    = (TPG_MODE_O == MODE_HI) ? MODE_LO : TPG_MODE_O + 4'd1;
    end

    always_ff @(posedge SYS_CLK_I) begin
        if (RST_I) begin
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            retry_cnt   <= '0;
            dwell_cnt   <= '0;
            led_cnt     <= '0;
        end else begin
            lock_m      <= LOCKED_I;
            lock_s      <= lock_m;
            led_cnt     <= led_cnt + 1'b1;
            rst_cnt     <= (state == ST_PLL_RST && next_state == ST_PLL_RST) ? rst_cnt + 1'b1 : '0;
            stable_cnt  <= (stay_wait && lock_s) ? stable_cnt + 1'b1 : '0;
            timeout_cnt <= stay_wait ? timeout_cnt + 1'b1 : '0;
            dwell_cnt   <= (stay_active && AUTO_CYCLE_I && !advance) ? dwell_cnt + 1'b1 : '0;
            if (next_state == ST_OFF || next_state == ST_ACTIVE) begin
                retry_cnt <= '0;
            end else if (state == ST_WAIT_LOCK && next_state != ST_WAIT_LOCK) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    // Outputs are decoded from next_state so they switch on the same edge as STATE_O.
    always_ff @(posedge SYS_CLK_I) begin
        if (RST_I) begin
            PLL_RST_O     <= 1'b1;
            DISP_RST_O    <= 1'b1;
            DEN_O         <= 1'b0;
            TPG_MODE_O    <= MODE_LO;
            MODE_STROBE_O <= 1'b0;
            FAULT_O       <= 1'b0;
            LED_O         <= 1'b0;
        end else begin
            PLL_RST_O     <= (next_state == ST_OFF) || (next_state == ST_PLL_RST) ||
                             (next_state == ST_FAULT);
            DISP_RST_O    <= (next_state != ST_ACTIVE);
            DEN_O         <= (next_state == ST_ACTIVE);
            FAULT_O       <= (next_state == ST_FAULT);
            MODE_STROBE_O <= advance;
            if (next_state == ST_OFF) begin
                TPG_MODE_O <= MODE_LO;
            end else if (advance) begin
                TPG_MODE_O <= mode_adv;
            end
            case (next_state)
                ST_PLL_RST, ST_WAIT_LOCK: LED_O <= 1'b1;
                ST_ACTIVE:                LED_O <= led_cnt[LED_DIV_BITS-1];
                ST_FAULT:                 LED_O <= led_cnt[LED_DIV_BITS-3];
                default:                  LED_O <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_tx_seq_ctrl.sv
// Directed bench for hdmi_tx_seq_ctrl: bring-up, lock glitch, retry/fault, auto and manual
// pattern stepping, and lock loss with mode retention.
module tb_hdmi_tx_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       display_on = 1'b0;
    logic       locked = 1'b0;
    logic       auto_cycle = 1'b0;
    logic       mode_next = 1'b0;
    logic       pll_rst, disp_rst, den, mode_strobe, fault, led;
    logic [3:0] tpg_mode;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    hdmi_tx_seq_ctrl #(
        .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(32),
        .MAX_RETRY(2), .DWELL_CYCLES(16), .MODE_MIN(1), .MODE_MAX(11), .LED_DIV_BITS(6)
    ) dut (
        .SYS_CLK_I(clk), .RST_I(rst), .DISPLAY_ON_I(display_on), .LOCKED_I(locked),
        .AUTO_CYCLE_I(auto_cycle), .MODE_NEXT_I(mode_next),
        .PLL_RST_O(pll_rst), .DISP_RST_O(disp_rst), .DEN_O(den), .TPG_MODE_O(tpg_mode),
        .MODE_STROBE_O(mode_strobe), .STATE_O(state), .FAULT_O(fault), .LED_O(led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mode_next();
        mode_next = 1'b1;
        tick();
        mode_next = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (state !== 3'd0 || pll_rst !== 1'b1 || disp_rst !== 1'b1 || den !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%0d pll_rst=%b disp_rst=%b den=%b, want 0/1/1/0",
                     state, pll_rst, disp_rst, den);
        end
        n_checks++;
        if (tpg_mode !== 4'd1 || mode_strobe !== 1'b0 || fault !== 1'b0 || led !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misc: mode=%0d strobe=%b fault=%b led=%b, want 1/0/0/0",
                     tpg_mode, mode_strobe, fault, led);
        end
    endtask

    task automatic test_bring_up();
        int n;
        display_on = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd1 || pll_rst !== 1'b1 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_pll_rst: state=%0d pll_rst=%b led=%b, want 1/1/1", state, pll_rst, led);
        end
        n = 0;
        while (state === 3'd1 && n < 20) begin
            n++;
            tick();
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL bringup_pll_rst_len: got %0d cycles, want 4", n);
        end
        n_checks++;
        if (state !== 3'd2 || pll_rst !== 1'b0 || disp_rst !== 1'b1 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_wait: state=%0d pll_rst=%b disp_rst=%b led=%b, want 2/0/1/1",
                     state, pll_rst, disp_rst, led);
        end
        locked = 1'b1;
        n = 0;
        while (state !== 3'd3 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL bringup_lock_latency: got %0d cycles, want 10", n);
        end
        n_checks++;
        if (den !== 1'b1 || disp_rst !== 1'b0 || tpg_mode !== 4'd1 || mode_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL bringup_active: den=%b disp_rst=%b mode=%0d strobe=%b, want 1/0/1/0",
                     den, disp_rst, tpg_mode, mode_strobe);
        end
    endtask

    task automatic test_lock_glitch();
        locked = 1'b0;
        tick();
        tick();
        n_checks++;
        if (den !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_loss_early: den=%b state=%0d, want 1/3", den, state);
        end
        tick();
        n_checks++;
        if (den !== 1'b0 || disp_rst !== 1'b1 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL glitch_loss: den=%b disp_rst=%b state=%0d, want 0/1/2", den, disp_rst, state);
        end
        for (int i = 1; i <= 16; i++) begin
            locked = (i == 6) ? 1'b0 : 1'b1;
            tick();
            if (i == 15) begin
                n_checks++;
                if (state !== 3'd2) begin
                    n_fail++;
                    $display("FAIL glitch_restart: state=%0d, want 2", state);
                end
            end
            if (i == 16) begin
                n_checks++;
                if (state !== 3'd3 || den !== 1'b1) begin
                    n_fail++;
                    $display("FAIL glitch_active: state=%0d den=%b, want 3/1", state, den);
                end
            end
        end
    endtask

    task automatic test_retry_fault();
        int  n;
        logic seen0, seen1;
        display_on = 1'b0;
        locked = 1'b0;
        tick();
        n_checks++;
        if (state !== 3'd0 || pll_rst !== 1'b1 || den !== 1'b0 || led !== 1'b0) begin
            n_fail++;
            $display("FAIL off_from_active: state=%0d pll_rst=%b den=%b led=%b, want 0/1/0/0",
                     state, pll_rst, den, led);
        end
        tick();
        tick();
        display_on = 1'b1;
        tick();
        for (int a = 0; a < 2; a++) begin
            n = 0;
            while (state === 3'd1 && n < 20) begin
                n++;
                tick();
            end
            n_checks++;
            if (n !== 4 || pll_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL retry_pll_rst_len[%0d]: got %0d cycles pll_rst=%b, want 4/0", a, n, pll_rst);
            end
            n = 0;
            while (state === 3'd2 && n < 100) begin
                n++;
                tick();
            end
            n_checks++;
            if (n !== 32) begin
                n_fail++;
                $display("FAIL retry_timeout_len[%0d]: got %0d cycles, want 32", a, n);
            end
            if (a == 0) begin
                n_checks++;
                if (state !== 3'd1 || pll_rst !== 1'b1) begin
                    n_fail++;
                    $display("FAIL retry_again: state=%0d pll_rst=%b, want 1/1", state, pll_rst);
                end
            end
        end
        n_checks++;
        if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b1 || disp_rst !== 1'b1 || den !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_entry: state=%0d fault=%b pll_rst=%b disp_rst=%b den=%b, want 4/1/1/1/0",
                     state, fault, pll_rst, disp_rst, den);
        end
        locked = 1'b1;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led === 1'b0) seen0 = 1'b1;
            if (led === 1'b1) seen1 = 1'b1;
        end
        n_checks++;
        if (!(seen0 && seen1) || state !== 3'd4) begin
            n_fail++;
            $display("FAIL fault_hold_blink: state=%0d led0=%b led1=%b, want 4/1/1", state, seen0, seen1);
        end
        display_on = 1'b0;
        tick();
        n_checks++;
        if (state !== 3'd0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_exit: state=%0d fault=%b, want 0/0", state, fault);
        end
    endtask

    task automatic test_auto_cycle();
        int        n;
        logic [3:0] exp_mode;
        logic       exp_strobe;
        display_on = 1'b1;
        locked = 1'b1;
        n = 0;
        while (state !== 3'd3 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (state !== 3'd3 || tpg_mode !== 4'd1) begin
            n_fail++;
            $display("FAIL auto_start: state=%0d mode=%0d, want 3/1", state, tpg_mode);
        end
        auto_cycle = 1'b1;
        exp_mode = 4'd1;
        for (int i = 0; i < 176; i++) begin
            tick();
            exp_strobe = ((i + 1) % 16 == 0);
            if (exp_strobe) exp_mode = (exp_mode == 4'd11) ? 4'd1 : exp_mode + 4'd1;
            n_checks++;
            if (mode_strobe !== exp_strobe || tpg_mode !== exp_mode) begin
                n_fail++;
                $display("FAIL auto_step[%0d]: strobe=%b mode=%0d, want %b/%0d",
                         i, mode_strobe, tpg_mode, exp_strobe, exp_mode);
            end
        end
        auto_cycle = 1'b0;
        tick();
        n_checks++;
        if (mode_strobe !== 1'b0 || tpg_mode !== 4'd1) begin
            n_fail++;
            $display("FAIL auto_stop: strobe=%b mode=%0d, want 0/1", mode_strobe, tpg_mode);
        end
    endtask

    task automatic test_simultaneous();
        for (int m = 2; m <= 5; m++) begin
            do_mode_next();
            n_checks++;
            if (tpg_mode !== 4'(m) || mode_strobe !== 1'b1) begin
                n_fail++;
                $display("FAIL manual_step: mode=%0d strobe=%b, want %0d/1", tpg_mode, mode_strobe, m);
            end
            tick();
            n_checks++;
            if (mode_strobe !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_strobe_width: strobe=%b, want 0", mode_strobe);
            end
        end
        auto_cycle = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (tpg_mode !== 4'd5 || mode_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_pre: mode=%0d strobe=%b, want 5/0", tpg_mode, mode_strobe);
        end
        do_mode_next();
        n_checks++;
        if (tpg_mode !== 4'd6 || mode_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_single_adv: mode=%0d strobe=%b, want 6/1", tpg_mode, mode_strobe);
        end
        tick();
        n_checks++;
        if (tpg_mode !== 4'd6 || mode_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_after: mode=%0d strobe=%b, want 6/0", tpg_mode, mode_strobe);
        end
        auto_cycle = 1'b0;
        for (int i = 0; i < 5; i++) do_mode_next();
        n_checks++;
        if (tpg_mode !== 4'd11) begin
            n_fail++;
            $display("FAIL manual_to_max: mode=%0d, want 11", tpg_mode);
        end
        do_mode_next();
        n_checks++;
        if (tpg_mode !== 4'd1 || mode_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL manual_wrap: mode=%0d strobe=%b, want 1/1", tpg_mode, mode_strobe);
        end
    endtask

    task automatic test_lock_loss_mid_run();
        int   n;
        logic seen_strobe;
        for (int i = 0; i < 6; i++) do_mode_next();
        tick();
        n_checks++;
        if (tpg_mode !== 4'd7 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL loss_setup: mode=%0d state=%0d, want 7/3", tpg_mode, state);
        end
        locked = 1'b0;
        seen_strobe = 1'b0;
        tick();
        tick();
        n_checks++;
        if (den !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_den_early: den=%b, want 1", den);
        end
        tick();
        n_checks++;
        if (den !== 1'b0 || state !== 3'd2 || tpg_mode !== 4'd7) begin
            n_fail++;
            $display("FAIL loss_wait: den=%b state=%0d mode=%0d, want 0/2/7", den, state, tpg_mode);
        end
        locked = 1'b1;
        n = 0;
        while (state !== 3'd3 && n < 40) begin
            tick();
            n++;
            if (mode_strobe === 1'b1) seen_strobe = 1'b1;
        end
        n_checks++;
        if (n !== 10 || tpg_mode !== 4'd7 || seen_strobe !== 1'b0 || den !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_relock: cycles=%0d mode=%0d strobe_seen=%b den=%b, want 10/7/0/1",
                     n, tpg_mode, seen_strobe, den);
        end
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_lock_glitch();
        test_retry_fault();
        test_auto_cycle();
        test_simultaneous();
        test_lock_loss_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
